// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control FSM and the multiply/divide unit.
// The master side drives requests; the slave side returns HI/LO and the handshake.
interface mult_div_unit_if #(parameter int N = 32);
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] rs_data;
    logic [N-1:0] rt_data;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (output start, op, rs_data, rt_data, input busy, done, hi, lo);
    modport slave  (input start, op, rs_data, rt_data, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Magnitude shift-add / restoring division over N cycles, sign fix-up in FINISH.
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t         state;
    logic [CW-1:0]  count;
    // acc_hi/acc_lo are the product halves for multiply, remainder/quotient for divide
    logic [N-1:0]   acc_hi;
    logic [N-1:0]   acc_lo;
    logic [N-1:0]   mcand;
    logic           is_div;
    logic           neg_q;
    logic           neg_r;
    logic           div_zero;

    logic           op_signed;
    logic [N-1:0]   rs_mag;
    logic [N-1:0]   rt_mag;
    logic [N:0]     mul_sum;
    logic [N:0]     rem_shift;
    logic           rem_ge;
    logic [N-1:0]   step_hi;
    logic [N-1:0]   step_lo;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;

    always_comb begin
        op_signed = (bus.op == 3'd0) || (bus.op == 3'd2);
        rs_mag    = (op_signed && bus.rs_data[N-1]) ? -bus.rs_data : bus.rs_data;
        rt_mag    = (op_signed && bus.rt_data[N-1]) ? -bus.rt_data : bus.rt_data;

        mul_sum   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
        rem_shift = {acc_hi, acc_lo[N-1]};
        rem_ge    = rem_shift >= {1'b0, mcand};

        if (is_div) begin
            step_hi = rem_ge ? N'(rem_shift - {1'b0, mcand}) : rem_shift[N-1:0];
            step_lo = {acc_lo[N-2:0], rem_ge};
        end else begin
            step_hi = mul_sum[N:1];
            step_lo = {mul_sum[0], acc_lo[N-1:1]};
        end

        prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        // divisor zero: remainder already equals the dividend, quotient forced to all ones
        q_fix    = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
        r_fix    = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mcand    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        case (bus.op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                is_div   <= bus.op[1];
                                acc_hi   <= '0;
                                acc_lo   <= bus.op[1] ? rs_mag : rt_mag;
                                mcand    <= bus.op[1] ? rt_mag : rs_mag;
                                neg_q    <= op_signed && (bus.rs_data[N-1] ^ bus.rt_data[N-1]);
                                neg_r    <= op_signed && bus.rs_data[N-1];
                                div_zero <= bus.op[1] && (bus.rt_data == '0);
                                count    <= '0;
                                bus.busy <= 1'b1;
                                state    <= RUN;
                            end
                            3'd4:    bus.hi <= bus.rs_data;
                            3'd5:    bus.lo <= bus.rs_data;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                    if (count == CW'(N - 1))
                        state <= FINISH;
                end
                FINISH: begin
                    if (is_div) begin
                        bus.hi <= r_fix;
                        bus.lo <= q_fix;
                    end else begin
                        bus.hi <= prod_fix[2*N-1:N];
                        bus.lo <= prod_fix[N-1:0];
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed and random ops against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    mult_div_unit_if #(.N(N)) bus ();
    mult_div_unit #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: signed ops via int/longint arithmetic, with the two architectural special cases.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        int          sa, sb;
        longint      p;
        logic [63:0] u;
        sa = a;
        sb = b;
        h  = exp_hi;
        l  = exp_lo;
        case (op)
            3'd0: begin p = longint'(sa) * longint'(sb); {h, l} = p; end
            3'd1: begin u = {32'd0, a} * {32'd0, b}; {h, l} = u; end
            3'd2: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 0; l = 32'h8000_0000; end
                else begin l = sa / sb; h = sa % sb; end
            end
            3'd3: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin l = a / b; h = a % b; end
            end
            default: ;
        endcase
    endfunction

    // Driver only: issues one iterative op (caller is at a negedge) and reports observations.
    // c counts negedge samples after the accepting edge; returns at the done sample.
    task automatic do_iter(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int busy_cyc, output int done_at, output int hold_err,
                           output logic [31:0] h, output logic [31:0] l);
        busy_cyc = 0;
        done_at  = -1;
        hold_err = 0;
        h = 'x;
        l = 'x;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start   = 1'b0;
                bus.rs_data = $urandom;
                bus.rt_data = $urandom;
            end
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.done === 1'b1) begin
                done_at = c;
                h = bus.hi;
                l = bus.lo;
                break;
            end
            if (bus.hi !== exp_hi || bus.lo !== exp_lo) hold_err++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b1;
        bus.op = 3'd4;
        bus.rs_data = 32'hDEAD_BEEF;
        bus.rt_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all zero", bus.busy, bus.done, bus.hi, bus.lo);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        exp_hi = 0;
        exp_lo = 0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b hi=%h lo=%h, want all zero", bus.busy, bus.done, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mthi_mtlo;
        logic [31:0] junk;
        bus.start = 1'b1; bus.op = 3'd4; bus.rs_data = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        exp_hi = 32'h1234_5678;
        n_checks++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b, want hi=%h lo=%h busy=0 done=0", bus.hi, bus.lo, bus.busy, bus.done, exp_hi, exp_lo);
        end
        bus.op = 3'd5; bus.rs_data = 32'hCAFE_F00D;
        @(posedge clk); @(negedge clk);
        exp_lo = 32'hCAFE_F00D;
        n_checks++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, want hi=%h lo=%h busy=0 done=0", bus.hi, bus.lo, bus.busy, bus.done, exp_hi, exp_lo);
        end
        junk = $urandom;
        bus.op = 3'd6; bus.rs_data = junk;
        @(posedge clk); @(negedge clk);
        bus.op = 3'd7;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL noop_ops: hi=%h lo=%h busy=%b done=%b, want hi=%h lo=%h busy=0 done=0", bus.hi, bus.lo, bus.busy, bus.done, exp_hi, exp_lo);
        end
    endtask

    task automatic test_mul;
        logic [2:0]  d_op [2] = '{3'd1, 3'd0};
        logic [31:0] d_a  [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
        logic [31:0] d_b  [2] = '{32'hFFFF_FFFF, 32'd7};
        logic [31:0] d_h  [2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] d_l  [2] = '{32'h0000_0001, 32'hFFFF_FFEB};
        logic [2:0]  op;
        logic [31:0] a, b, h, l, mh, ml;
        int          bc, da, he;
        for (int i = 0; i < 14; i++) begin
            if (i < 2) begin
                op = d_op[i]; a = d_a[i]; b = d_b[i]; mh = d_h[i]; ml = d_l[i];
            end else begin
                op = 3'($urandom_range(0, 1));
                a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
                b  = $urandom;
                model(op, a, b, mh, ml);
            end
            do_iter(op, a, b, bc, da, he, h, l);
            n_checks++;
            if (bc != N + 1 || da != N + 2 || he != 0) begin
                n_fail++;
                $display("FAIL mul_timing[%0d]: busy_cycles=%0d done_sample=%0d hold_errs=%0d, want %0d %0d 0", i, bc, da, he, N + 1, N + 2);
            end
            n_checks++;
            if (h !== mh || l !== ml) begin
                n_fail++;
                $display("FAIL mul_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h, want hi=%h lo=%h", i, op, a, b, h, l, mh, ml);
            end
            exp_hi = mh;
            exp_lo = ml;
        end
    endtask

    task automatic test_div;
        logic [2:0]  d_op [5] = '{3'd3, 3'd2, 3'd2, 3'd3, 3'd2};
        logic [31:0] d_a  [5] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000};
        logic [31:0] d_b  [5] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] d_h  [5] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd0};
        logic [31:0] d_l  [5] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [2:0]  op;
        logic [31:0] a, b, h, l, mh, ml;
        int          bc, da, he, sel;
        for (int i = 0; i < 25; i++) begin
            if (i < 5) begin
                op = d_op[i]; a = d_a[i]; b = d_b[i]; mh = d_h[i]; ml = d_l[i];
            end else begin
                op  = 3'($urandom_range(2, 3));
                a   = $urandom;
                b   = $urandom;
                sel = $urandom_range(0, 7);
                if (sel == 0) b = 0;
                else if (sel == 1) b = 32'hFFFF_FFFF;
                else if (sel == 2) a = 32'h8000_0000;
                else if (sel == 3) b = $urandom_range(1, 50);
                model(op, a, b, mh, ml);
            end
            do_iter(op, a, b, bc, da, he, h, l);
            n_checks++;
            if (bc != N + 1 || da != N + 2 || he != 0) begin
                n_fail++;
                $display("FAIL div_timing[%0d]: busy_cycles=%0d done_sample=%0d hold_errs=%0d, want %0d %0d 0", i, bc, da, he, N + 1, N + 2);
            end
            n_checks++;
            if (h !== mh || l !== ml) begin
                n_fail++;
                $display("FAIL div_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h, want hi=%h lo=%h", i, op, a, b, h, l, mh, ml);
            end
            exp_hi = mh;
            exp_lo = ml;
        end
    endtask

    task automatic test_busy_ignore;
        int          n_done, done_at, bc, da, he;
        logic [31:0] a, b, h, l, mh, ml;
        n_done  = 0;
        done_at = -1;
        bus.start = 1'b1; bus.op = 3'd1; bus.rs_data = 32'd3; bus.rt_data = 32'd4;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 5)  begin bus.start = 1'b1; bus.op = 3'd3; bus.rs_data = 32'd9; bus.rt_data = 32'd3; end
            if (c == 10) begin bus.start = 1'b1; bus.op = 3'd5; bus.rs_data = 32'h0000_AAAA; end
            if (bus.done === 1'b1) begin
                n_done++;
                done_at = c;
                break;
            end
        end
        n_checks++;
        if (n_done != 1 || done_at != N + 2 || bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
            n_fail++;
            $display("FAIL busy_ignore: dones=%0d done_sample=%0d hi=%h lo=%h, want 1 %0d hi=0 lo=c", n_done, done_at, bus.hi, bus.lo, N + 2);
        end
        exp_hi = 0;
        exp_lo = 12;
        // issue the next op in the done cycle itself
        a = $urandom;
        b = $urandom;
        model(3'd1, a, b, mh, ml);
        do_iter(3'd1, a, b, bc, da, he, h, l);
        n_checks++;
        if (bc != N + 1 || da != N + 2 || he != 0 || h !== mh || l !== ml) begin
            n_fail++;
            $display("FAIL back_to_back: busy_cycles=%0d done_sample=%0d hold_errs=%0d hi=%h lo=%h, want %0d %0d 0 %h %h", bc, da, he, h, l, N + 1, N + 2, mh, ml);
        end
        exp_hi = mh;
        exp_lo = ml;
    endtask

    task automatic test_reset_abort;
        int          bc, da, he;
        logic [31:0] h, l;
        bus.start = 1'b1; bus.op = 3'd4; bus.rs_data = 32'h55;
        @(posedge clk); @(negedge clk);
        exp_hi = 32'h55;
        n_checks++;
        if (bus.hi !== exp_hi) begin
            n_fail++;
            $display("FAIL abort_mthi: hi=%h, want %h", bus.hi, exp_hi);
        end
        bus.op = 3'd2; bus.rs_data = 32'd100; bus.rt_data = 32'd3;
        @(posedge clk);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h, want all zero", bus.busy, bus.done, bus.hi, bus.lo);
        end
        rst = 1'b0;
        exp_hi = 0;
        exp_lo = 0;
        @(negedge clk);
        do_iter(3'd3, 32'd100, 32'd3, bc, da, he, h, l);
        n_checks++;
        if (bc != N + 1 || da != N + 2 || he != 0 || h !== 32'd1 || l !== 32'd33) begin
            n_fail++;
            $display("FAIL abort_recover: busy_cycles=%0d done_sample=%0d hold_errs=%0d hi=%h lo=%h, want %0d %0d 0 hi=1 lo=21", bc, da, he, h, l, N + 1, N + 2);
        end
        exp_hi = 1;
        exp_lo = 33;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        rst         = 1'b1;
        exp_hi      = 0;
        exp_lo      = 0;
        test_reset;
        test_mthi_mtlo;
        test_mul;
        test_div;
        test_busy_ignore;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath. Sits directly downstream of the register file: consumes rd_data1/rd_data2 (rs/rt) and produces the HI/LO pair.
- The writeback mux forwards HI/LO to the register file write port for MFHI/MFLO.
- Implements MULT, MULTU, DIV, DIVU (N iterations, shift-add and restoring division) plus single-cycle MTHI/MTLO.
- Drives a busy/done handshake so the control FSM stalls MFHI/MFLO and further mul/div ops.

Parameters:
N, 32, operand width; hi/lo are N bits each; iteration count = N; counter width = $clog2(N)+1.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
rs_data  input  N  rs operand (multiplicand / dividend / MTHI-MTLO source), from rd_data1
rt_data  input  N  rt operand (multiplier / divisor), from rd_data2
busy  output  1  high while an iterative op is in flight
done  output  1  one-cycle pulse when hi/lo receive an iterative result
hi  output  N  HI register
lo  output  N  LO register

Behaviour:
- Reset: on any rising edge with rst=1, the following apply, and rst overrides start.
  - State becomes IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - Counter and internal accumulators are cleared.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - done is 0 in every cycle except the one following FINISH.
  - start=1 with op 0-3: latch operand magnitudes (absolute value for signed ops, raw for unsigned), latch sign flags and op, count=0, go to RUN.
  - start=1 with op 4 (MTHI): hi<=rs_data at this edge; stay IDLE; busy and done stay 0; lo unchanged.
  - start=1 with op 5 (MTLO): lo<=rs_data at this edge; stay IDLE; busy and done stay 0; hi unchanged.
  - start=1 with op 6 or 7: ignored.
- RUN:
  - One iteration per edge; count increments.
  - After the N-th iteration, go to FINISH.
  - Multiply: 2N-bit product register, shift-add LSB-first.
  - Divide: restoring division on an N+1-bit partial remainder, quotient shifted in MSB-first.
- FINISH:
  - Apply sign correction to the magnitude result.
  - Signed multiply: negate the 2N-bit product when the operand signs differ.
  - Signed divide: quotient negated when the operand signs differ; remainder takes the sign of the dividend.
  - Write hi/lo at this edge.
    - Multiply: hi = product upper half, lo = product lower half.
    - Divide: hi = remainder, lo = quotient.
  - done=1 for exactly this following cycle; go to IDLE.
- busy is a registered output, equal to 1 while state is RUN or FINISH.
- Timing: a start accepted at edge k gives busy=1 after edge k. hi/lo update and done=1 after edge k+N+1, with busy=0 in that same cycle. Latency is N+1 cycles (33 for N=32).
- hi/lo hold their previous values throughout RUN/FINISH. Operand inputs may change freely after acceptance.
- start while busy=1 is ignored entirely, including MTHI/MTLO. The control FSM must hold the request.
- A new start is accepted in the cycle done=1, since state is then IDLE.
- Divide by zero (rt_data=0, signed or unsigned): hi=rs_data, lo={N{1'b1}}. Same N+1 latency, done pulses.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Falls out of the magnitude algorithm with N-bit truncation.
- The most negative operand (0x80000000) is handled as the magnitude 2^31 in unsigned N-bit form.
- Reset asserted mid-operation aborts the op: next cycle busy=0, done=0, hi=lo=0.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high for 33 cycles; done pulses on the 33rd cycle after start; hi=0xFFFFFFFE, lo=0x00000001. MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. DIVU rs=100 rt=7 -> lo=14, hi=2. DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV rs=7 rt=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
3. DIVU rs=5 rt=0 -> hi=5, lo=0xFFFFFFFF. DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0. Each case has done after 33 cycles.
4. MTHI rs=0x12345678, then MTLO rs=0xCAFEF00D on consecutive cycles -> hi and lo update one edge after each request; busy and done remain 0 throughout.
5. Start MULTU 3*4; during busy, pulse start with DIVU 9/3 and MTLO 0xAAAA -> the busy requests are ignored; final hi=0, lo=12; exactly one done pulse. Issue a new op in the done cycle -> accepted, busy back to 1 on the next cycle.
6. MTHI 0x55 completed, then start DIV 100/3 and assert rst on cycle 10 -> next cycle busy=0, done=0, hi=0, lo=0. After rst drops, a fresh DIVU 100/3 yields lo=33, hi=1.
